// File: rtl/iob_eth_bd_responder.sv
// Ethernet buffer-descriptor CPU responder: BD RAM, TX/RX byte FIFOs, status.
// Optional bus-error reporting is enabled by defining IOB_ETH_BD_RESPONDER_BUSERR_EN.
module iob_eth_bd_responder #(
    parameter int DATA_W      = 32,
    parameter int ADDR_W      = 12,
    parameter int BD_NUM_LOG2 = 7,
    parameter int FIFO_W      = 4
) (
    input  logic                   clk_i,
    input  logic                   arst_n_i,
    input  logic                   iob_valid_i,
    input  logic [ADDR_W-1:0]      iob_addr_i,
    input  logic [DATA_W-1:0]      iob_wdata_i,
    input  logic [DATA_W/8-1:0]    iob_wstrb_i,
    output logic                   iob_ready_o,
    output logic                   iob_rvalid_o,
    output logic [DATA_W-1:0]      iob_rdata_o,
    output logic [7:0]             tx_data_o,
    output logic                   tx_valid_o,
    input  logic                   tx_ready_i,
    input  logic [7:0]             rx_data_i,
    input  logic                   rx_valid_i,
    output logic                   rx_ready_o,
    input  logic [BD_NUM_LOG2-1:0] bd_addr_i,
    output logic [31:0]            bd_rdata_o
);

    localparam int BD_NUM = 2 ** BD_NUM_LOG2;
    localparam int DEPTH  = 2 ** FIFO_W;
    localparam int WA_W   = ADDR_W - 2;
    localparam logic [WA_W-1:0] BD_BASE = WA_W'(256);
    localparam logic [WA_W-1:0] BD_END  = WA_W'(256 + BD_NUM);
    localparam logic [FIFO_W:0] FULL_CNT = (FIFO_W + 1)'(DEPTH);

    logic [31:0] bd_mem [BD_NUM];
    logic [7:0]  tx_mem [DEPTH];
    logic [7:0]  rx_mem [DEPTH];

    logic [FIFO_W-1:0] tx_wp, tx_rp, rx_wp, rx_rp;
    logic [FIFO_W:0]   tx_cnt, rx_cnt;
    logic              tx_full, rx_empty;
    logic              tx_push, tx_pop, rx_push, rx_pop;

    logic [WA_W-1:0]        word, bd_off;
    logic [BD_NUM_LOG2-1:0] bd_idx;
    logic sel_status, sel_nbytes, sel_frame, sel_bd, unmapped;
    logic wr, acc, acc_rd, acc_wr;
    logic [DATA_W-1:0] rdata_next;
    logic err;
    logic unused_bits;

    assign word       = iob_addr_i[ADDR_W-1:2];
    assign bd_off     = word - BD_BASE;
    assign bd_idx     = bd_off[BD_NUM_LOG2-1:0];
    assign sel_status = (word == WA_W'(0));
    assign sel_nbytes = (word == WA_W'(1));
    assign sel_frame  = (word == WA_W'(2));
    assign sel_bd     = (word >= BD_BASE) && (word < BD_END);
    assign unmapped   = !(sel_status || sel_nbytes || sel_frame || sel_bd);
    assign unused_bits = ^{iob_addr_i[1:0], bd_off[WA_W-1:BD_NUM_LOG2]};

    assign tx_full  = (tx_cnt == FULL_CNT);
    assign rx_empty = (rx_cnt == '0);
    assign wr       = |iob_wstrb_i;

    // Stall only the FIFO accesses that cannot complete this cycle
    always_comb begin
        iob_ready_o = 1'b1;
        if (sel_frame && wr && tx_full)
            iob_ready_o = 1'b0;
        if (sel_frame && !wr && rx_empty)
            iob_ready_o = 1'b0;
    end

    assign acc    = iob_valid_i && iob_ready_o;
    assign acc_rd = acc && !wr;
    assign acc_wr = acc && wr;

    assign tx_push = acc_wr && sel_frame && iob_wstrb_i[0];
    assign tx_pop  = tx_valid_o && tx_ready_i;
    assign rx_push = rx_valid_i && rx_ready_o;
    assign rx_pop  = acc_rd && sel_frame;

    assign tx_valid_o = (tx_cnt != '0);
    assign tx_data_o  = tx_mem[tx_rp];
    assign rx_ready_o = (rx_cnt != FULL_CNT);

`ifdef IOB_ETH_BD_RESPONDER_BUSERR_EN
    localparam logic [DATA_W-1:0] UNMAPPED_RDATA = DATA_W'(32'hDEADBEEF);

    always_ff @(posedge clk_i or negedge arst_n_i) begin
        if (!arst_n_i)
            err <= 1'b0;
        else if (acc && unmapped)
            err <= 1'b1;
        else if (acc_wr && sel_status && iob_wdata_i[2])
            err <= 1'b0;
    end
`else
    localparam logic [DATA_W-1:0] UNMAPPED_RDATA = '0;

    assign err = 1'b0;
`endif

    always_comb begin
        rdata_next = UNMAPPED_RDATA;
        unique case (1'b1)
            sel_status: rdata_next = DATA_W'({err, rx_empty, tx_full});
            sel_nbytes: rdata_next = DATA_W'(rx_cnt);
            sel_frame:  rdata_next = DATA_W'(rx_mem[rx_rp]);
            sel_bd:     rdata_next = DATA_W'(bd_mem[bd_idx]);
            default:    rdata_next = UNMAPPED_RDATA;
        endcase
    end

    // Storage arrays carry no reset; contents are owned by software/FIFO state
    always_ff @(posedge clk_i) begin
        if (acc_wr && sel_bd)
            for (int b = 0; b < DATA_W / 8; b++)
                if (iob_wstrb_i[b])
                    bd_mem[bd_idx][8*b +: 8] <= iob_wdata_i[8*b +: 8];
        if (tx_push)
            tx_mem[tx_wp] <= iob_wdata_i[7:0];
        if (rx_push)
            rx_mem[rx_wp] <= rx_data_i;
    end

    always_ff @(posedge clk_i or negedge arst_n_i) begin
        if (!arst_n_i) begin
            tx_wp  <= '0;
            tx_rp  <= '0;
            tx_cnt <= '0;
            rx_wp  <= '0;
            rx_rp  <= '0;
            rx_cnt <= '0;
        end else begin
            if (tx_push)
                tx_wp <= tx_wp + 1'b1;
            if (tx_pop)
                tx_rp <= tx_rp + 1'b1;
            if (rx_push)
                rx_wp <= rx_wp + 1'b1;
            if (rx_pop)
                rx_rp <= rx_rp + 1'b1;
            tx_cnt <= tx_cnt + (FIFO_W + 1)'(tx_push) - (FIFO_W + 1)'(tx_pop);
            rx_cnt <= rx_cnt + (FIFO_W + 1)'(rx_push) - (FIFO_W + 1)'(rx_pop);
        end
    end

    always_ff @(posedge clk_i or negedge arst_n_i) begin
        if (!arst_n_i) begin
            iob_rvalid_o <= 1'b0;
            iob_rdata_o  <= '0;
            bd_rdata_o   <= '0;
        end else begin
            iob_rvalid_o <= acc_rd;
            if (acc_rd)
                iob_rdata_o <= rdata_next;
            bd_rdata_o <= bd_mem[bd_addr_i];
        end
    end

endmodule

// File: tb/tb_iob_eth_bd_responder.sv
// Bench for iob_eth_bd_responder: vector table plus FIFO/reset sequences,
// with read-data and TX-byte scoreboards checked by a negedge monitor.
module tb_iob_eth_bd_responder;

`ifdef IOB_ETH_BD_RESPONDER_BUSERR_EN
    localparam logic [31:0] UNM  = 32'hDEADBEEF;
    localparam logic [31:0] ERRB = 32'h4;
`else
    localparam logic [31:0] UNM  = 32'h0;
    localparam logic [31:0] ERRB = 32'h0;
`endif

    logic        clk_i, arst_n_i;
    logic        iob_valid_i;
    logic [11:0] iob_addr_i;
    logic [31:0] iob_wdata_i;
    logic [3:0]  iob_wstrb_i;
    logic        iob_ready_o, iob_rvalid_o;
    logic [31:0] iob_rdata_o;
    logic [7:0]  tx_data_o;
    logic        tx_valid_o, tx_ready_i;
    logic [7:0]  rx_data_i;
    logic        rx_valid_i, rx_ready_o;
    logic [6:0]  bd_addr_i;
    logic [31:0] bd_rdata_o;

    iob_eth_bd_responder dut (
        .clk_i(clk_i), .arst_n_i(arst_n_i),
        .iob_valid_i(iob_valid_i), .iob_addr_i(iob_addr_i),
        .iob_wdata_i(iob_wdata_i), .iob_wstrb_i(iob_wstrb_i),
        .iob_ready_o(iob_ready_o), .iob_rvalid_o(iob_rvalid_o),
        .iob_rdata_o(iob_rdata_o),
        .tx_data_o(tx_data_o), .tx_valid_o(tx_valid_o), .tx_ready_i(tx_ready_i),
        .rx_data_i(rx_data_i), .rx_valid_i(rx_valid_i), .rx_ready_o(rx_ready_o),
        .bd_addr_i(bd_addr_i), .bd_rdata_o(bd_rdata_o)
    );

    typedef struct {
        logic [11:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
        logic [31:0] exp;
    } vec_t;

    vec_t        vec [23];
    int          n_cmp = 0;
    int          n_bad = 0;
    logic [31:0] rd_q [$];
    logic [7:0]  tx_q [$];
    bit          rv_due = 0;

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h, want 0x%08h", name, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk_i);
        #1;
    endtask

    always @(negedge clk_i) begin
        if (!arst_n_i) begin
            rv_due = 0;
            rd_q.delete();
        end else begin
            if (iob_rvalid_o || rv_due)
                chk("rvalid_timing", 32'(iob_rvalid_o), 32'(rv_due));
            if (iob_rvalid_o) begin
                if (rd_q.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL rdata_unexpected: got 0x%08h, want no rvalid", iob_rdata_o);
                end else begin
                    chk("rdata", iob_rdata_o, rd_q.pop_front());
                end
            end
            if (tx_valid_o && tx_ready_i) begin
                if (tx_q.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL tx_unexpected: got 0x%02h, want no byte", tx_data_o);
                end else begin
                    chk("tx_data", 32'(tx_data_o), 32'(tx_q.pop_front()));
                end
            end
            rv_due = iob_valid_i && iob_ready_o && (iob_wstrb_i == 4'h0);
        end
    end

    task automatic bus(input logic [11:0] a, input logic [31:0] d,
                       input logic [3:0] s, input logic [31:0] exp);
        bit ok = 0;
        if (s == 4'h0)
            rd_q.push_back(exp);
        if (s[0] && a == 12'h008)
            tx_q.push_back(d[7:0]);
        iob_addr_i  = a;
        iob_wdata_i = d;
        iob_wstrb_i = s;
        iob_valid_i = 1'b1;
        for (int i = 0; i < 50 && !ok; i++) begin
            @(negedge clk_i);
            ok = iob_ready_o;
            tick();
        end
        iob_valid_i = 1'b0;
        iob_wstrb_i = 4'h0;
        if (!ok) begin
            n_cmp++;
            n_bad++;
            $display("FAIL bus_timeout: addr 0x%03h never accepted, want ready", a);
            if (s == 4'h0)
                void'(rd_q.pop_back());
        end
    endtask

    task automatic rx_send(input logic [7:0] b);
        bit ok = 0;
        rx_data_i  = b;
        rx_valid_i = 1'b1;
        for (int i = 0; i < 50 && !ok; i++) begin
            @(negedge clk_i);
            ok = rx_ready_o;
            tick();
        end
        rx_valid_i = 1'b0;
        if (!ok) begin
            n_cmp++;
            n_bad++;
            $display("FAIL rx_timeout: got rx_ready 0, want 1");
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, want completion");
        $fatal(1, "watchdog");
    end

    initial begin
        vec[0]  = '{12'h000, 32'h0,        4'h0, 32'h2};
        vec[1]  = '{12'h004, 32'h0,        4'h0, 32'h0};
        vec[2]  = '{12'h500, 32'h0000A5C3, 4'hF, 32'h0};
        vec[3]  = '{12'h500, 32'h0,        4'h0, 32'h0000A5C3};
        vec[4]  = '{12'h500, 32'h0000FF00, 4'h2, 32'h0};
        vec[5]  = '{12'h500, 32'h0,        4'h0, 32'h0000FFC3};
        vec[6]  = '{12'h404, 32'h12345678, 4'hF, 32'h0};
        vec[7]  = '{12'h404, 32'hAABBCCDD, 4'h9, 32'h0};
        vec[8]  = '{12'h404, 32'h0,        4'h0, 32'hAA3456DD};
        vec[9]  = '{12'h5FC, 32'hCAFEF00D, 4'hF, 32'h0};
        vec[10] = '{12'h5FC, 32'h0,        4'h0, 32'hCAFEF00D};
        vec[11] = '{12'h400, 32'h01020304, 4'hF, 32'h0};
        vec[12] = '{12'h400, 32'h0,        4'h0, 32'h01020304};
        vec[13] = '{12'h00C, 32'h0,        4'h0, UNM};
        vec[14] = '{12'h000, 32'h0,        4'h0, 32'h2 | ERRB};
        vec[15] = '{12'h000, 32'h4,        4'hF, 32'h0};
        vec[16] = '{12'h000, 32'h0,        4'h0, 32'h2};
        vec[17] = '{12'h600, 32'h0,        4'h0, UNM};
        vec[18] = '{12'h3FC, 32'hFFFFFFFF, 4'hF, 32'h0};
        vec[19] = '{12'h000, 32'h0,        4'h0, 32'h2 | ERRB};
        vec[20] = '{12'h000, 32'h4,        4'h1, 32'h0};
        vec[21] = '{12'h5FC, 32'h0,        4'h0, 32'hCAFEF00D};
        vec[22] = '{12'h008, 32'h000000EE, 4'h2, 32'h0};

        arst_n_i    = 1'b0;
        iob_valid_i = 1'b0;
        iob_addr_i  = '0;
        iob_wdata_i = '0;
        iob_wstrb_i = '0;
        tx_ready_i  = 1'b0;
        rx_data_i   = '0;
        rx_valid_i  = 1'b0;
        bd_addr_i   = '0;

        repeat (2) @(negedge clk_i);
        chk("rst_rvalid", 32'(iob_rvalid_o), 32'h0);
        chk("rst_rdata", iob_rdata_o, 32'h0);
        chk("rst_bd_rdata", bd_rdata_o, 32'h0);
        chk("rst_tx_valid", 32'(tx_valid_o), 32'h0);
        chk("rst_rx_ready", 32'(rx_ready_o), 32'h1);
        tick();
        arst_n_i = 1'b1;
        tick();

        for (int i = 0; i < $size(vec); i++)
            bus(vec[i].addr, vec[i].wdata, vec[i].wstrb, vec[i].exp);
        bus(12'h000, 32'h0, 4'h0, 32'h2);

        bd_addr_i = 7'd64;
        tick();
        @(negedge clk_i);
        chk("mac_bd64", bd_rdata_o, 32'h0000FFC3);
        tick();

        bus(12'h414, 32'h11111111, 4'hF, 32'h0);
        bd_addr_i = 7'd5;
        bus(12'h414, 32'h22222222, 4'hF, 32'h0);
        @(negedge clk_i);
        chk("mac_raw_old", bd_rdata_o, 32'h11111111);
        tick();
        @(negedge clk_i);
        chk("mac_raw_new", bd_rdata_o, 32'h22222222);
        tick();

        rx_send(8'h11);
        rx_send(8'h22);
        rx_send(8'h33);
        bus(12'h004, 32'h0, 4'h0, 32'h3);
        bus(12'h008, 32'h0, 4'h0, 32'h11);
        bus(12'h008, 32'h0, 4'h0, 32'h22);
        bus(12'h008, 32'h0, 4'h0, 32'h33);

        rd_q.push_back(32'h44);
        iob_addr_i  = 12'h008;
        iob_wstrb_i = 4'h0;
        iob_valid_i = 1'b1;
        repeat (3) begin
            @(negedge clk_i);
            chk("rx_empty_stall", 32'(iob_ready_o), 32'h0);
            tick();
        end
        rx_data_i  = 8'h44;
        rx_valid_i = 1'b1;
        @(negedge clk_i);
        chk("rx_arrive_stall", 32'(iob_ready_o), 32'h0);
        tick();
        rx_valid_i = 1'b0;
        @(negedge clk_i);
        chk("rx_arrive_ready", 32'(iob_ready_o), 32'h1);
        tick();
        iob_valid_i = 1'b0;
        tick();

        rx_send(8'h55);
        for (int i = 0; i < 16; i++)
            bus(12'h008, 32'h12345600 | 32'(8'hA0 + i[7:0]), 4'h1, 32'h0);
        bus(12'h000, 32'h0, 4'h0, 32'h1);

        tx_q.push_back(8'hB0);
        iob_addr_i  = 12'h008;
        iob_wdata_i = 32'h000000B0;
        iob_wstrb_i = 4'h1;
        iob_valid_i = 1'b1;
        repeat (2) begin
            @(negedge clk_i);
            chk("tx_full_stall", 32'(iob_ready_o), 32'h0);
            tick();
        end
        tx_ready_i = 1'b1;
        @(negedge clk_i);
        chk("tx_pop_same_cycle", 32'(iob_ready_o), 32'h0);
        tick();
        @(negedge clk_i);
        chk("tx_17th_accept", 32'(iob_ready_o), 32'h1);
        tick();
        iob_valid_i = 1'b0;
        iob_wstrb_i = 4'h0;
        repeat (20) tick();
        chk("tx_drained", 32'(tx_q.size()), 32'h0);
        chk("tx_valid_idle", 32'(tx_valid_o), 32'h0);
        bus(12'h000, 32'h0, 4'h0, 32'h0);
        bus(12'h008, 32'h0, 4'h0, 32'h55);
        bus(12'h000, 32'h0, 4'h0, 32'h2);

        rx_send(8'h66);
        rx_send(8'h77);
        iob_addr_i  = 12'h008;
        iob_wstrb_i = 4'h0;
        iob_valid_i = 1'b1;
        @(negedge clk_i);
        chk("rst_seq_ready", 32'(iob_ready_o), 32'h1);
        tick();
        arst_n_i    = 1'b0;
        iob_valid_i = 1'b0;
        @(negedge clk_i);
        chk("rst_drop_rvalid", 32'(iob_rvalid_o), 32'h0);
        chk("rst_seq_rx_ready", 32'(rx_ready_o), 32'h1);
        tick();
        arst_n_i = 1'b1;
        tick();
        bus(12'h004, 32'h0, 4'h0, 32'h0);
        bus(12'h000, 32'h0, 4'h0, 32'h2);
        repeat (3) tick();
        chk("rd_queue_drained", 32'(rd_q.size()), 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/iob_eth_bd_responder.md
IOB_ETH_BD_RESPONDER -- requirements
Module: iob_eth_bd_responder

Interface
REQ-001 SHALL have parameter DATA_W, default 32, CPU data width; only 32 is supported.
REQ-002 SHALL have parameter ADDR_W, default 12, CPU byte-address width.
REQ-003 SHALL have parameter BD_NUM_LOG2, default 7, log2 of the buffer-descriptor count (128 BDs: TX 0..63, RX 64..127).
REQ-004 SHALL have parameter FIFO_W, default 4, log2 of the TX and RX byte-FIFO depth (16 entries each).
REQ-005 SHALL have port clk_i, input, 1: the single clock; all logic on the rising edge.
REQ-006 SHALL have port arst_n_i, input, 1: reset, asynchronous, active-low.
REQ-007 SHALL have port iob_valid_i, input, 1: CPU request valid.
REQ-008 SHALL have port iob_addr_i, input, ADDR_W: byte address; bits [1:0] ignored.
REQ-009 SHALL have port iob_wdata_i, input, DATA_W: write data.
REQ-010 SHALL have port iob_wstrb_i, input, DATA_W/8: byte enables; nonzero means write, zero means read.
REQ-011 SHALL have port iob_ready_o, output, 1: request accepted this cycle.
REQ-012 SHALL have port iob_rvalid_o, output, 1: read data valid.
REQ-013 SHALL have port iob_rdata_o, output, DATA_W: read data.
REQ-014 SHALL have TX byte stream ports tx_data_o [7:0], tx_valid_o, tx_ready_i.
REQ-015 SHALL have RX byte stream ports rx_data_i [7:0], rx_valid_i, rx_ready_o.
REQ-016 SHALL have a MAC-side BD read port: bd_addr_i [BD_NUM_LOG2-1:0] in, bd_rdata_o [31:0] out, registered with 1-cycle latency.

Function
REQ-017 SHALL decode the address map: 0x000 STATUS (RO), 0x004 RX_NBYTES (RO), 0x008 FRAME_WORD (RW), 0x400+4n BD n (RW); every other address is unmapped.
REQ-018 SHALL set STATUS as bit0 TX FIFO full, bit1 RX FIFO empty, bit2 bus-error sticky (see REQ-032), and all other bits 0.
REQ-019 SHALL return the RX FIFO occupancy in RX_NBYTES, zero-extended to 32 bits.
REQ-020 SHALL form iob_ready_o combinationally from current state: 0 for a FRAME_WORD write while the TX FIFO is full, 0 for a FRAME_WORD read while the RX FIFO is empty, otherwise 1; it is a don't-care when iob_valid_i=0.
REQ-021 SHALL treat a request as accepted when iob_valid_i & iob_ready_o; an accepted read SHALL pulse iob_rvalid_o for exactly one cycle on the next cycle, with registered iob_rdata_o; writes SHALL produce no rvalid.
REQ-022 SHALL push wdata[7:0] into the TX FIFO on an accepted FRAME_WORD write with wstrb[0]=1; other strobe bits are ignored.
REQ-023 SHALL pop one RX byte on an accepted FRAME_WORD read and return it in rdata[7:0] with the upper bits 0.
REQ-024 SHALL apply BD writes per byte strobe; a BD read SHALL return the stored word.
REQ-025 SHALL, when the CPU and the MAC access the same BD in one cycle, return old data on bd_rdata_o (read-before-write).
REQ-026 SHALL drive tx_valid_o = TX FIFO non-empty and rx_ready_o = RX FIFO non-full; a transfer occurs on valid&ready.
REQ-027 SHALL handle a simultaneous push and pop on either FIFO as a count-neutral operation; a full or empty condition blocks per REQ-020 and REQ-026 even when the opposite side transfers in the same cycle.
REQ-028 SHALL wrap FIFO pointers modulo 2^FIFO_W and keep occupancy counters FIFO_W+1 bits wide.

Reset
REQ-029 SHALL, on arst_n_i low, immediately clear iob_rvalid_o, iob_rdata_o, bd_rdata_o, the FIFO pointers and counters, and the error sticky bit; tx_valid_o then reads 0, rx_ready_o 1, and STATUS 0x2.
REQ-030 SHALL leave BD memory contents undefined after reset; software initialises them.
REQ-031 SHALL, if reset asserts mid-transaction, drop any pending rvalid and discard all FIFO data.

Configuration
REQ-032 SHALL, with IOB_ETH_BD_RESPONDER_BUSERR_EN defined, return 0xDEADBEEF on an unmapped read and set STATUS bit2 on any unmapped access, cleared only by a STATUS write with wdata[2]=1 or by reset.
REQ-033 SHALL, without IOB_ETH_BD_RESPONDER_BUSERR_EN, return 0 on an unmapped read, ignore unmapped writes, and read STATUS bit2 as 0.

Verification
REQ-034 SHALL cover: write 0x0000A5C3 to BD 64 (addr 0x500, wstrb 0xF), then read it -> rvalid exactly 1 cycle after acceptance, rdata=0x0000A5C3.
REQ-035 SHALL cover: write wstrb=0x2, wdata=0x0000FF00 to BD 64 holding 0x0000A5C3 -> readback 0x0000FFC3.
REQ-036 SHALL cover: 17 FRAME_WORD writes with tx_ready_i=0 -> ready low on the 17th and STATUS=0x1; raise tx_ready_i -> the 17th is accepted next cycle and tx_data_o emits bytes in order.
REQ-037 SHALL cover: drive 3 RX bytes 0x11,0x22,0x33 -> RX_NBYTES=3; three FRAME_WORD reads -> 0x11,0x22,0x33; a 4th read stalls until a new byte arrives.
REQ-038 SHALL cover: read 0x0C -> 0xDEADBEEF and STATUS bit2=1 with the macro; 0x00000000 and bit2=0 without it.
REQ-039 SHALL cover: assert arst_n_i low on the cycle after a read is accepted -> rvalid not asserted, RX_NBYTES=0, STATUS=0x2.
